// File: rtl/pulse_train_gen_if.sv
// pulse_train_gen_if: command/status bundle between the CPU PIO ports and the pulse train generator
//   master: drives GO_I (start request) and CNT_I (pulse count), observes the status outputs
//   slave : receives GO_I/CNT_I, drives PULSE_O, BUSY_O, DONE_O, SENT_O
interface pulse_train_gen_if;
  logic       GO_I;
  logic [7:0] CNT_I;
  logic       PULSE_O;
  logic       BUSY_O;
  logic       DONE_O;
  logic [7:0] SENT_O;
  modport master(output GO_I, CNT_I, input PULSE_O, BUSY_O, DONE_O, SENT_O);
  modport slave(input GO_I, CNT_I, output PULSE_O, BUSY_O, DONE_O, SENT_O);
endinterface

// File: rtl/pulse_train_gen.sv
// pulse_train_gen: emits CNT_I timed pulses on PULSE_O after a rising edge of GO_I
//   CLK_I : system clock, RST_I : synchronous active-high reset
//   bus   : GO_I/CNT_I command in; PULSE_O, BUSY_O, DONE_O, SENT_O status out (all registered)
module pulse_train_gen #(
  parameter int HIGH_CYC = 25_000_000,
  parameter int LOW_CYC  = 25_000_000,
  parameter int CNT_WL   = 32
) (
  input logic              CLK_I,
  input logic              RST_I,
  pulse_train_gen_if.slave bus
);
  typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;
  state_t              state_q, state_d;
  logic                go_q;
  logic [7:0]          remaining_q, remaining_d;
  logic [7:0]          sent_q, sent_d;
  logic [CNT_WL-1:0]   timer_q, timer_d;
  logic                pulse_q, pulse_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                accept, hi_end, lo_end;
  // go_q resets high so a GO_I held through reset is not seen as an edge
  assign accept = state_q == IDLE && bus.GO_I && !go_q && bus.CNT_I != 8'd0;
  assign hi_end = state_q == HIGH && timer_q == CNT_WL'(HIGH_CYC - 1);
  assign lo_end = state_q == LOW && timer_q == CNT_WL'(LOW_CYC - 1);
  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      state_q     <= IDLE;
      go_q        <= 1'b1;
      remaining_q <= '0;
      sent_q      <= '0;
      timer_q     <= '0;
      pulse_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      go_q        <= bus.GO_I;
      remaining_q <= remaining_d;
      sent_q      <= sent_d;
      timer_q     <= timer_d;
      pulse_q     <= pulse_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end
  always_comb begin
    state_d     = accept ? HIGH : hi_end ? LOW : lo_end ? (remaining_q != 8'd0 ? HIGH : IDLE) : state_q;
    remaining_d = accept ? bus.CNT_I : hi_end ? remaining_q - 8'd1 : remaining_q;
    sent_d      = accept ? 8'd0 : hi_end ? sent_q + 8'd1 : sent_q;
    timer_d     = (state_d != state_q || state_q == IDLE) ? '0 : timer_q + 1'b1;
  end
  // outputs are registered from the next state so they line up with the state they describe
  always_comb begin
    pulse_d = state_d == HIGH;
    busy_d  = state_d != IDLE;
    done_d  = lo_end && remaining_q == 8'd0;
  end
  assign bus.PULSE_O = pulse_q;
  assign bus.BUSY_O  = busy_q;
  assign bus.DONE_O  = done_q;
  assign bus.SENT_O  = sent_q;
endmodule
